// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronises the PS/2 lines, deserialises
// 11-bit frames and strobes each accepted scan code out on key_rdy.
module ps2_rx #(
   parameter bit CHECK_PARITY   = 1'b1,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst_l,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       key_rdy,
   output logic [7:0] key_out
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t state, state_n;

   logic          clk_s1, clk_s2, clk_prev;
   logic          data_s1, data_s2;
   logic          ps2_clk_neg_edge;
   logic [2:0]    bit_cnt, bit_cnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par_ok, par_ok_n;
   logic [TW-1:0] tmo, tmo_n;
   logic [7:0]    key_out_n;
   logic          key_rdy_n;

   assign ps2_clk_neg_edge = clk_prev & ~clk_s2;

   always_ff @(posedge clk or posedge rst_l) begin
      if (rst_l) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
         state    <= IDLE;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_ok   <= 1'b0;
         tmo      <= '0;
         key_out  <= '0;
         key_rdy  <= 1'b0;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         data_s1  <= ps2_data;
         data_s2  <= data_s1;
         state    <= state_n;
         bit_cnt  <= bit_cnt_n;
         shreg    <= shreg_n;
         par_ok   <= par_ok_n;
         tmo      <= tmo_n;
         key_out  <= key_out_n;
         key_rdy  <= key_rdy_n;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      par_ok_n  = par_ok;
      key_out_n = key_out;
      key_rdy_n = 1'b0;

      if (state == IDLE || ps2_clk_neg_edge)
         tmo_n = '0;
      else
         tmo_n = tmo + TW'(1);

      unique case (state)
         IDLE: begin
            if (ps2_clk_neg_edge && !data_s2) begin
               state_n   = DATA;
               bit_cnt_n = '0;
            end
         end
         DATA: begin
            if (ps2_clk_neg_edge) begin
               shreg_n[bit_cnt] = data_s2;
               bit_cnt_n        = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7)
                  state_n = PARITY;
            end
         end
         PARITY: begin
            if (ps2_clk_neg_edge) begin
               par_ok_n = ^{shreg, data_s2};
               state_n  = STOP;
            end
         end
         STOP: begin
            if (ps2_clk_neg_edge) begin
               if (data_s2 && (par_ok || !CHECK_PARITY)) begin
                  key_out_n = shreg;
                  key_rdy_n = 1'b1;
               end
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      // A stalled partial frame is dropped without touching key_out
      if (state != IDLE && !ps2_clk_neg_edge
          && tmo == TW'(TIMEOUT_CYCLES))
         state_n = IDLE;
   end

endmodule

// File: tb/tb_ps2_rx.sv
// Bench for ps2_rx: parity-checking and parity-ignoring instances share the
// PS/2 lines; a scoreboard queue per instance holds the expected scan codes.
module tb_ps2_rx;

   localparam int TMO = 200;
   localparam int HP  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic       rdy_a, rdy_b;
   logic [7:0] out_a, out_b;

   ps2_rx #(.CHECK_PARITY(1'b1), .TIMEOUT_CYCLES(TMO)) dut_a (
      .clk(clk), .rst_l(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_rdy(rdy_a), .key_out(out_a));

   ps2_rx #(.CHECK_PARITY(1'b0), .TIMEOUT_CYCLES(TMO)) dut_b (
      .clk(clk), .rst_l(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_rdy(rdy_b), .key_out(out_b));

   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk)
      if (dut_a.ps2_clk_neg_edge) edges <= edges + 1;

   typedef struct {
      logic [7:0] d;
      bit         bad_par;
      bit         stop;
      bit         exp_a;
      bit         exp_b;
   } vec_t;

   vec_t       vecs[6];
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic [7:0] last_a = 8'h00;
   logic [7:0] last_b = 8'h00;
   int         n_cmp = 0;
   int         n_err = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic ps2_bit(bit b);
      ps2_data = b;
      repeat (HP) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HP) @(posedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(logic [7:0] d, bit bad_par, bit stop);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(~(^d) ^ bad_par);
      ps2_bit(stop);
      ps2_data = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   task automatic expect_a(logic [7:0] d);
      qa.push_back(d);
      last_a = d;
   endtask

   task automatic expect_b(logic [7:0] d);
      qb.push_back(d);
      last_b = d;
   endtask

   task automatic monitor();
      logic [7:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_a) begin
            if (qa.size() == 0) chk("a_unexpected_rdy", {24'h0, out_a}, 32'hFFFF);
            else begin
               e = qa.pop_front();
               chk("a_key_out_on_rdy", {24'h0, out_a}, {24'h0, e});
            end
         end
         if (rdy_b) begin
            if (qb.size() == 0) chk("b_unexpected_rdy", {24'h0, out_b}, 32'hFFFF);
            else begin
               e = qb.pop_front();
               chk("b_key_out_on_rdy", {24'h0, out_b}, {24'h0, e});
            end
         end
      end
   endtask

   task automatic post_check(string tag);
      chk({tag, "_qa_drained"}, qa.size(), 0);
      chk({tag, "_qb_drained"}, qb.size(), 0);
      chk({tag, "_key_out_a"}, {24'h0, out_a}, {24'h0, last_a});
      chk({tag, "_key_out_b"}, {24'h0, out_b}, {24'h0, last_b});
   endtask

   initial begin
      int e0;
      int wait_cnt;
      vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1};
      vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[4] = '{8'hA5, 1'b0, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1};

      fork
         monitor();
      join_none

      // Reset held while the PS/2 clock toggles with data low
      ps2_data = 1'b0;
      for (int i = 0; i < 6; i++) begin
         repeat (HP) @(posedge clk);
         ps2_clk = ~ps2_clk;
      end
      ps2_clk = 1'b1;
      repeat (HP) @(posedge clk);
      #1;
      chk("rst_key_rdy", {31'h0, rdy_a}, 0);
      chk("rst_key_out", {24'h0, out_a}, 0);
      chk("rst_no_edges", edges, 0);
      rst = 1'b0;
      ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_key_out", {24'h0, out_a}, 0);

      foreach (vecs[i]) begin
         e0 = edges;
         if (vecs[i].exp_a) expect_a(vecs[i].d);
         if (vecs[i].exp_b) expect_b(vecs[i].d);
         send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop);
         chk($sformatf("vec%0d_edges", i), edges - e0, 11);
         post_check($sformatf("vec%0d", i));
      end

      // Back-to-back: start bit right on the edge after the stop bit
      expect_a(8'h3C);
      expect_b(8'h3C);
      expect_a(8'h81);
      expect_b(8'h81);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(1'((8'h3C >> i) & 1));
      ps2_bit(1'b1);
      ps2_bit(1'b1);
      send_frame(8'h81, 1'b0, 1'b1);
      post_check("b2b");

      // Timeout: partial frame abandoned, next frame decoded cleanly
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      ps2_data = 1'b1;
      repeat (TMO + 100) @(posedge clk);
      expect_a(8'h5A);
      expect_b(8'h5A);
      send_frame(8'h5A, 1'b0, 1'b1);
      post_check("timeout");

      // Idle-high clocking never starts a frame
      for (int i = 0; i < 20; i++) ps2_bit(1'b1);
      repeat (10) @(posedge clk);
      post_check("idle_high");

      // Reset mid-frame aborts; key_out returns to zero
      ps2_bit(1'b0);
      for (int i = 0; i < 3; i++) ps2_bit(1'b0);
      rst = 1'b1;
      last_a = 8'h00;
      last_b = 8'h00;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_key_out", {24'h0, out_a}, 0);
      rst = 1'b0;
      ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      for (int i = 0; i < 6; i++) ps2_bit(1'b1);
      repeat (10) @(posedge clk);
      post_check("midrst_quiet");
      expect_a(8'h1C);
      expect_b(8'h1C);
      send_frame(8'h1C, 1'b0, 1'b1);

      wait_cnt = 0;
      while ((qa.size() != 0 || qb.size() != 0) && wait_cnt < 200) begin
         @(posedge clk);
         wait_cnt++;
      end
      chk("final_wait_bound", {31'h0, wait_cnt >= 200}, 0);
      post_check("final");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
